wb_uart_master: RTL and testbench
=================================

// Module: wb_uart_master
// PURPOSE
//  Serial debug bridge: receives command frames on a UART and issues single 32-bit Wishbone
//  master cycles, returning status/read data over the same UART. Initiator-side counterpart
//  of the Wishbone UART slave; lets a host PC peek/poke any SoC register without the CPU.
// PARAMETERS
//  clk_freq    100000000  system clock in Hz, passed to uart engine
//  baud        38400      serial bit rate, passed to uart engine
//  RX_TIMEOUT  1000000    clk cycles allowed between frame bytes before frame is dropped
//  WB_TIMEOUT  255        clk cycles to wait for wb_ack_i before cycle is aborted
// PORTS
//  clk       in   1   system clock, all logic on rising edge
//  reset     in   1   synchronous, active-low reset
//  uart_rxd  in   1   serial input from host
//  uart_txd  out  1   serial output to host
//  wb_cyc_o  out  1   Wishbone cycle
//  wb_stb_o  out  1   Wishbone strobe
//  wb_we_o   out  1   1 = write cycle
//  wb_adr_o  out  32  byte address
//  wb_sel_o  out  4   byte selects, always 4'hF during a cycle
//  wb_dat_o  out  32  write data
//  wb_dat_i  in   32  read data, sampled on the wb_ack_i cycle
//  wb_ack_i  in   1   slave acknowledge
//  busy_o    out  1   high whenever FSM is not in IDLE
// BEHAVIOUR
//  Reset (reset==0): all outputs 0 except uart_txd=1 (idle line); FSM=IDLE; counters cleared.
//  uart engine gets reset=~reset (engine is active-high). All bytes MSB first.
//  Frames: 'W'(0x57) A3 A2 A1 A0 D3 D2 D1 D0 -> write; reply 0x06 (ACK).
//          'R'(0x52) A3 A2 A1 A0             -> read;  reply D3 D2 D1 D0.
//          Error reply for any WB timeout: single byte 0x15 (NAK), no data bytes.
//  RX consumption: on rx_avail pulse rx_ack for exactly 1 cycle, then ignore rx_avail 1 cycle.
//  FSM states: IDLE -> ADDR -> [DATA] -> WB -> RESP -> IDLE.
//   IDLE: byte 0x57/0x52 latches we, goes ADDR; any other byte (or rx_error) dropped, stay IDLE.
//   ADDR: 4 bytes shifted into wb_adr_o; after 4th -> DATA if write, else WB.
//   DATA: 4 bytes shifted into wb_dat_o; after 4th -> WB.
//   WB: cyc/stb/sel asserted from next cycle; held until wb_ack_i or WB_TIMEOUT cycles.
//       Ack: cyc/stb/sel drop in the following cycle; read latches wb_dat_i into tx shift reg.
//       Ack asserted same cycle as timeout expiry counts as ack. Exactly one strobe per frame.
//   RESP: tx_wr 1-cycle pulse only when ~tx_busy; after each tx_wr wait 1 cycle before
//       resampling tx_busy. Byte count: 1 (ACK/NAK) or 4 (read data). Then IDLE.
//  Inter-byte timeout: in ADDR/DATA a counter resets on each accepted byte; reaching
//   RX_TIMEOUT returns to IDLE with no Wishbone cycle and no reply. rx_error mid-frame: same.
//  Bytes arriving during WB/RESP: acknowledged and discarded (no queueing).
//  Reset asserted mid-cycle: cyc/stb drop the next edge; no reply is sent.
//  Byte counter 2 bits, wraps 3->0 on the terminal byte; WB counter saturates at WB_TIMEOUT.
// STRUCTURE
//  Shared package wb_uart_pkg: command opcodes 0x57/0x52, reply codes 0x06/0x15, FSM state
//   encoding (3 bits). Single sub-module instance: existing uart engine (uart0); all framing,
//   Wishbone sequencing and timeouts in this module, no further hierarchy.
// TESTING
//  1 'W' 00 00 00 10 DE AD BE EF, slave acks after 3 cyc -> one write adr 0x10 dat 0xDEADBEEF,
//    sel 0xF, cyc high exactly 4 cyc; reply byte 0x06.
//  2 'R' 00 00 00 04, slave returns 0x12345678 with ack -> one read adr 0x04; reply 12 34 56 78.
//  3 'R' 00 00 00 08, no slave ack -> cyc/stb drop after WB_TIMEOUT cycles; reply 0x15 only.
//  4 0x41 then valid 'W' frame -> 0x41 ignored, no reply; following write executes normally.
//  5 'W' 00 00 then silence > RX_TIMEOUT -> no WB cycle, no reply; new 'R' frame then works.
//  6 reset low during WB state -> cyc/stb/we 0 next edge, uart_txd stays 1, busy_o 0.

Source files
------------

// File: rtl/wb_uart_pkg.sv
// Shared definitions for the UART-to-Wishbone debug bridge: command and reply
// byte codes, and the framing FSM state encoding.
package wb_uart_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_WB   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/wb_uart_master_uart.sv
// 8N1 UART engine: oversampled receiver with held rx byte and one-cycle error
// strobe, plus a single-byte transmitter. Active-high synchronous reset.
module wb_uart_master_uart #(
  parameter int clk_freq = 100000000,
  parameter int baud     = 38400
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic       txd_o,
  output logic [7:0] rx_data_o,
  output logic       rx_avail_o,
  output logic       rx_error_o,
  input  logic       rx_ack_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_wr_i,
  output logic       tx_busy_o
);

  localparam int DIV = clk_freq / baud;
  localparam int CW  = $clog2(DIV);

  logic [1:0]    rx_s_q;
  logic          rx_busy_q, rx_avail_q, rx_error_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_sh_q, rx_data_q;

  // Start edge arms a half-bit delay so every later sample lands mid-bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s_q     <= 2'b11;
      rx_busy_q  <= 1'b0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 4'd0;
      rx_sh_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_avail_q <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      rx_s_q     <= {rx_s_q[0], rxd_i};
      rx_error_q <= 1'b0;
      if (rx_ack_i) rx_avail_q <= 1'b0;
      if (!rx_busy_q) begin
        if (!rx_s_q[1]) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= CW'(DIV / 2);
          rx_bit_q  <= 4'd0;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - 1'b1;
      end else begin
        rx_cnt_q <= CW'(DIV - 1);
        rx_bit_q <= rx_bit_q + 1'b1;
        if (rx_bit_q == 4'd0) begin
          if (rx_s_q[1]) rx_busy_q <= 1'b0;
        end else if (rx_bit_q == 4'd9) begin
          rx_busy_q <= 1'b0;
          if (rx_s_q[1]) begin
            rx_data_q  <= rx_sh_q;
            rx_avail_q <= 1'b1;
          end else begin
            rx_error_q <= 1'b1;
          end
        end else begin
          rx_sh_q <= {rx_s_q[1], rx_sh_q[7:1]};
        end
      end
    end
  end

  logic          tx_busy_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic [9:0]    tx_sh_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_busy_q <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= 4'd0;
      tx_sh_q   <= '1;
    end else if (!tx_busy_q) begin
      if (tx_wr_i) begin
        tx_sh_q   <= {1'b1, tx_data_i, 1'b0};
        tx_busy_q <= 1'b1;
        tx_cnt_q  <= CW'(DIV - 1);
        tx_bit_q  <= 4'd0;
      end
    end else if (tx_cnt_q != '0) begin
      tx_cnt_q <= tx_cnt_q - 1'b1;
    end else begin
      tx_cnt_q <= CW'(DIV - 1);
      if (tx_bit_q == 4'd9) begin
        tx_busy_q <= 1'b0;
      end else begin
        tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
        tx_bit_q <= tx_bit_q + 1'b1;
      end
    end
  end

  assign txd_o      = tx_busy_q ? tx_sh_q[0] : 1'b1;
  assign tx_busy_o  = tx_busy_q;
  assign rx_data_o  = rx_data_q;
  assign rx_avail_o = rx_avail_q;
  assign rx_error_o = rx_error_q;

endmodule

// File: rtl/wb_uart_master.sv
// UART command-frame decoder driving single 32-bit Wishbone master cycles and
// returning ACK/NAK or read data over the same serial link.
module wb_uart_master
  import wb_uart_pkg::*;
#(
  parameter int clk_freq   = 100000000,
  parameter int baud       = 38400,
  parameter int RX_TIMEOUT = 1000000,
  parameter int WB_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        busy_o
);

  localparam int RXW = $clog2(RX_TIMEOUT + 1);
  localparam int WBW = $clog2(WB_TIMEOUT + 1);

  logic [7:0] rx_data, tx_data;
  logic       rx_avail, rx_error, rx_ack, tx_wr, tx_busy;

  wb_uart_master_uart #(.clk_freq(clk_freq), .baud(baud)) uart0 (
    .clk_i      (clk),
    .rst_i      (~reset),
    .rxd_i      (uart_rxd),
    .txd_o      (uart_txd),
    .rx_data_o  (rx_data),
    .rx_avail_o (rx_avail),
    .rx_error_o (rx_error),
    .rx_ack_i   (rx_ack),
    .tx_data_i  (tx_data),
    .tx_wr_i    (tx_wr),
    .tx_busy_o  (tx_busy)
  );

  state_e          state_q, state_d;
  logic            we_q, we_d, cyc_q, cyc_d, skip_q, skip_d, txwait_q, txwait_d;
  logic [31:0]     adr_q, adr_d, dat_q, dat_d, tx_sr_q, tx_sr_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [RXW-1:0]  rxt_q, rxt_d;
  logic [WBW-1:0]  wbt_q, wbt_d;

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    cyc_d    = cyc_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    tx_sr_d  = tx_sr_q;
    bcnt_d   = bcnt_q;
    rxt_d    = rxt_q;
    wbt_d    = wbt_q;
    txwait_d = txwait_q;
    // Every available byte is consumed in any state; bytes outside a frame are just dropped.
    rx_ack   = rx_avail && !skip_q;
    skip_d   = rx_ack;
    tx_wr    = 1'b0;
    tx_data  = tx_sr_q[31:24];
    case (state_q)
      ST_IDLE: begin
        if (rx_ack && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
          we_d    = (rx_data == CMD_WRITE);
          state_d = ST_ADDR;
          bcnt_d  = 2'd0;
          rxt_d   = '0;
        end
      end
      ST_ADDR, ST_DATA: begin
        if (rx_error) begin
          state_d = ST_IDLE;
        end else if (rx_ack) begin
          rxt_d  = '0;
          bcnt_d = bcnt_q + 2'd1;
          if (state_q == ST_ADDR) adr_d = {adr_q[23:0], rx_data};
          else                    dat_d = {dat_q[23:0], rx_data};
          if (bcnt_q == 2'd3) begin
            if (state_q == ST_ADDR && we_q) begin
              state_d = ST_DATA;
            end else begin
              state_d = ST_WB;
              cyc_d   = 1'b1;
              wbt_d   = '0;
            end
          end
        end else if (rxt_q == RXW'(RX_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          rxt_d = rxt_q + 1'b1;
        end
      end
      ST_WB: begin
        // Ack wins over a timeout expiring in the same cycle.
        if (!cyc_q) begin
          state_d = ST_IDLE;
        end else if (wb_ack_i) begin
          cyc_d    = 1'b0;
          state_d  = ST_RESP;
          txwait_d = 1'b0;
          if (we_q) begin
            tx_sr_d = {RSP_ACK, 24'h0};
            bcnt_d  = 2'd0;
          end else begin
            tx_sr_d = wb_dat_i;
            bcnt_d  = 2'd3;
          end
        end else if (wbt_q == WBW'(WB_TIMEOUT - 1)) begin
          cyc_d    = 1'b0;
          state_d  = ST_RESP;
          txwait_d = 1'b0;
          tx_sr_d  = {RSP_NAK, 24'h0};
          bcnt_d   = 2'd0;
        end else begin
          wbt_d = wbt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (txwait_q) begin
          txwait_d = 1'b0;
        end else if (!tx_busy) begin
          tx_wr    = 1'b1;
          tx_sr_d  = {tx_sr_q[23:0], 8'h00};
          txwait_d = 1'b1;
          bcnt_d   = bcnt_q - 2'd1;
          if (bcnt_q == 2'd0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      cyc_q    <= 1'b0;
      adr_q    <= 32'h0;
      dat_q    <= 32'h0;
      tx_sr_q  <= 32'h0;
      bcnt_q   <= 2'd0;
      rxt_q    <= '0;
      wbt_q    <= '0;
      skip_q   <= 1'b0;
      txwait_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      cyc_q    <= cyc_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      tx_sr_q  <= tx_sr_d;
      bcnt_q   <= bcnt_d;
      rxt_q    <= rxt_d;
      wbt_q    <= wbt_d;
      skip_q   <= skip_d;
      txwait_q <= txwait_d;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_sel_o = {4{cyc_q}};
  assign wb_we_o  = cyc_q & we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_uart_master.sv
// Bench for wb_uart_master: serial frame driver, serial reply decoder, a
// Wishbone slave with programmable ack latency, and a frame-level reference model.
module tb_wb_uart_master;

  localparam int CLK_FREQ = 1600;
  localparam int BAUD     = 100;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int RX_TO    = 400;
  localparam int WB_TO    = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        uart_rxd = 1'b1;
  logic        uart_txd;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_ack_i = 1'b0;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  wb_uart_master #(.clk_freq(CLK_FREQ), .baud(BAUD), .RX_TIMEOUT(RX_TO), .WB_TIMEOUT(WB_TO)) dut (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Wishbone slave: acks on the (ack_delay+1)-th cycle that cyc is high.
  int          ack_delay = 1000;
  logic [31:0] slave_rdata = 32'h0;
  int          cyc_cnt = 0, n_cyc = 0, last_len = 0, sig_bad = 0;
  logic [31:0] cap_adr, cap_dat;
  logic        cap_we;

  initial begin
    forever begin
      @(negedge clk);
      if (wb_cyc_o === 1'b1) begin
        cyc_cnt++;
        if (wb_stb_o !== 1'b1 || wb_sel_o !== 4'hF) sig_bad++;
        if (cyc_cnt == 1) begin
          n_cyc++;
          cap_adr = wb_adr_o;
          cap_dat = wb_dat_o;
          cap_we  = wb_we_o;
        end
        if (cyc_cnt == ack_delay + 1) begin
          wb_ack_i = 1'b1;
          wb_dat_i = slave_rdata;
        end else begin
          wb_ack_i = 1'b0;
        end
      end else begin
        if (reset === 1'b1 && (wb_stb_o !== 1'b0 || wb_sel_o !== 4'h0)) sig_bad++;
        if (cyc_cnt != 0) last_len = cyc_cnt;
        cyc_cnt  = 0;
        wb_ack_i = 1'b0;
      end
    end
  end

  // Serial decoder for bytes sent by the DUT (8N1, LSB first on the wire).
  logic [7:0] reply_q[$];
  logic [7:0] mon_b;
  int         mon_ferr = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (uart_txd === 1'b0) begin
        repeat (BIT / 2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(posedge clk);
          #1;
          mon_b[i] = uart_txd;
        end
        repeat (BIT) @(posedge clk);
        #1;
        if (uart_txd !== 1'b1) mon_ferr++;
        reply_q.push_back(mon_b);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  logic [7:0] frame_b[0:8];

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (BIT + 4) @(negedge clk);
  endtask

  task automatic set_w(input logic [31:0] a, input logic [31:0] d);
    frame_b[0] = 8'h57;
    for (int i = 0; i < 4; i++) begin
      frame_b[1 + i] = a[31 - 8 * i -: 8];
      frame_b[5 + i] = d[31 - 8 * i -: 8];
    end
  endtask

  task automatic set_r(input logic [31:0] a);
    frame_b[0] = 8'h52;
    for (int i = 0; i < 4; i++) frame_b[1 + i] = a[31 - 8 * i -: 8];
  endtask

  // Reference model: derive expected bus cycle and reply bytes from the frame bytes.
  task automatic run_frame(input string nm, input int len, input int delay, input logic [31:0] rdata);
    logic        is_w, is_r, acked, exp_we;
    int          exp_txn, exp_len, base, waited;
    logic [31:0] exp_adr, exp_dat;
    logic [7:0]  exp_reply[$];
    is_w    = (frame_b[0] == 8'h57) && (len == 9);
    is_r    = (frame_b[0] == 8'h52) && (len == 5);
    exp_txn = (is_w || is_r) ? 1 : 0;
    exp_we  = is_w;
    exp_adr = {frame_b[1], frame_b[2], frame_b[3], frame_b[4]};
    exp_dat = {frame_b[5], frame_b[6], frame_b[7], frame_b[8]};
    acked   = (delay < WB_TO);
    exp_len = acked ? delay + 1 : WB_TO;
    exp_reply.delete();
    if (exp_txn == 1) begin
      if (!acked)    exp_reply.push_back(8'h15);
      else if (is_w) exp_reply.push_back(8'h06);
      else for (int i = 0; i < 4; i++) exp_reply.push_back(rdata[31 - 8 * i -: 8]);
    end

    ack_delay   = delay;
    slave_rdata = rdata;
    base        = n_cyc;
    reply_q.delete();
    for (int i = 0; i < len; i++) send_byte(frame_b[i]);
    if (exp_reply.size() > 0) begin
      waited = 0;
      while (reply_q.size() < exp_reply.size() && waited < 4000) begin
        @(posedge clk);
        waited++;
      end
      if (waited >= 4000) begin
        checks++;
        failures++;
        $display("FAIL %s reply_wait: got %0d bytes, required %0d", nm, reply_q.size(), exp_reply.size());
      end
      repeat (250) @(posedge clk);
    end else begin
      repeat (RX_TO + 200) @(posedge clk);
    end

    checks++;
    if (n_cyc - base !== exp_txn) begin
      failures++;
      $display("FAIL %s wb_cycles: got %0d, required %0d", nm, n_cyc - base, exp_txn);
    end
    if (exp_txn == 1 && n_cyc - base == 1) begin
      checks++;
      if (cap_adr !== exp_adr) begin
        failures++;
        $display("FAIL %s adr: got %h, required %h", nm, cap_adr, exp_adr);
      end
      checks++;
      if (cap_we !== exp_we) begin
        failures++;
        $display("FAIL %s we: got %b, required %b", nm, cap_we, exp_we);
      end
      if (is_w) begin
        checks++;
        if (cap_dat !== exp_dat) begin
          failures++;
          $display("FAIL %s dat: got %h, required %h", nm, cap_dat, exp_dat);
        end
      end
      checks++;
      if (last_len !== exp_len) begin
        failures++;
        $display("FAIL %s cyc_len: got %0d, required %0d", nm, last_len, exp_len);
      end
    end
    checks++;
    if (reply_q.size() !== exp_reply.size()) begin
      failures++;
      $display("FAIL %s reply_len: got %0d, required %0d", nm, reply_q.size(), exp_reply.size());
    end else begin
      for (int i = 0; i < exp_reply.size(); i++) begin
        checks++;
        if (reply_q[i] !== exp_reply[i]) begin
          failures++;
          $display("FAIL %s reply[%0d]: got %h, required %h", nm, i, reply_q[i], exp_reply[i]);
        end
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_end: got %b, required 0", nm, busy_o);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, busy_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctl: got cyc/stb/we/busy=%b, required 0000", {wb_cyc_o, wb_stb_o, wb_we_o, busy_o});
    end
    checks++;
    if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 68'h0) begin
      failures++;
      $display("FAIL reset_bus: got adr=%h dat=%h sel=%h, required 0", wb_adr_o, wb_dat_o, wb_sel_o);
    end
    checks++;
    if (uart_txd !== 1'b1) begin
      failures++;
      $display("FAIL reset_txd: got %b, required 1", uart_txd);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_write();
    set_w(32'h0000_0010, 32'hDEAD_BEEF);
    run_frame("write", 9, 3, 32'h0);
  endtask

  task automatic test_read();
    set_r(32'h0000_0004);
    run_frame("read", 5, 1, 32'h1234_5678);
  endtask

  task automatic test_wb_timeout();
    set_r(32'h0000_0008);
    run_frame("wb_timeout", 5, 1000, 32'hFFFF_FFFF);
    set_w(32'hA000_0000, 32'h0102_0304);
    run_frame("ack_at_limit", 9, WB_TO - 1, 32'h0);
    set_r(32'hA000_0004);
    run_frame("ack_past_limit", 5, WB_TO, 32'h5555_AAAA);
  endtask

  task automatic test_bad_cmd();
    reply_q.delete();
    send_byte(8'h41);
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0 || reply_q.size() != 0) begin
      failures++;
      $display("FAIL bad_cmd_ignored: got busy=%b replies=%0d, required 0 0", busy_o, reply_q.size());
    end
    set_w(32'h0000_0020, 32'hCAFE_F00D);
    run_frame("after_bad_cmd", 9, 0, 32'h0);
  endtask

  task automatic test_rx_timeout();
    frame_b[0] = 8'h57;
    frame_b[1] = 8'h00;
    frame_b[2] = 8'h00;
    run_frame("rx_timeout", 3, 0, 32'h0);
    set_r(32'h0000_0030);
    run_frame("after_rx_timeout", 5, 2, 32'h89AB_CDEF);
  endtask

  task automatic test_random();
    for (int n = 0; n < 5; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        set_w($urandom, $urandom);
        run_frame("rand_write", 9, $urandom_range(0, WB_TO + 2), 32'h0);
      end else begin
        set_r($urandom);
        run_frame("rand_read", 5, $urandom_range(0, WB_TO + 2), $urandom);
      end
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    set_r(32'h0000_0040);
    ack_delay = 1000;
    reply_q.delete();
    for (int i = 0; i < 5; i++) send_byte(frame_b[i]);
    waited = 0;
    while (wb_cyc_o !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (wb_cyc_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_cyc_start: got cyc=%b, required 1", wb_cyc_o);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, busy_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_ctl: got cyc/stb/we/busy=%b, required 0000", {wb_cyc_o, wb_stb_o, wb_we_o, busy_o});
    end
    checks++;
    if (uart_txd !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_txd: got %b, required 1", uart_txd);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    checks++;
    if (reply_q.size() != 0 || uart_txd !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_no_reply: got replies=%0d txd=%b, required 0 1", reply_q.size(), uart_txd);
    end
  endtask

  task automatic test_bus_signals();
    checks++;
    if (sig_bad != 0) begin
      failures++;
      $display("FAIL bus_signals: got %0d bad stb/sel cycles, required 0", sig_bad);
    end
    checks++;
    if (mon_ferr != 0) begin
      failures++;
      $display("FAIL tx_framing: got %0d bad stop bits, required 0", mon_ferr);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wb_timeout();
    test_bad_cmd();
    test_rx_timeout();
    test_random();
    test_reset_mid();
    test_bus_signals();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
